// File: rtl/dtw_result_collector.sv
// dtw_result_collector: drains the 3-word DTW result records {qid, position, minval}
// from the result FIFO, presents each one on a valid/ready port with a threshold-hit
// flag, and keeps best-hit registers plus saturating record/hit counters.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   enable            permit new FIFO reads
//   clear             synchronous clear of counters, best registers, frame_err
//   threshold         a record is a hit when minval < threshold
//   fifo_rden         FIFO read enable (combinational)
//   fifo_empty        FIFO empty flag
//   fifo_data         FIFO data, valid the cycle after an accepted read
//   rec_valid/ready   record handshake
//   rec_qid, rec_position, rec_minval, rec_hit   record payload
//   best_valid, best_qid, best_position, best_minval   lowest-cost hit so far
//   rec_count, hit_count   accepted records / accepted hits (saturating)
//   frame_err         sticky: upper bits of the minval word were nonzero
//   busy              partial record held or record pending

module dtw_result_collector #(
  parameter int unsigned axi_dwidth = 32,
  parameter int unsigned dtw_dwidth = 16,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [dtw_dwidth-1:0] threshold,
  output logic                  fifo_rden,
  input  logic                  fifo_empty,
  input  logic [axi_dwidth-1:0] fifo_data,
  output logic                  rec_valid,
  input  logic                  rec_ready,
  output logic [axi_dwidth-1:0] rec_qid,
  output logic [axi_dwidth-1:0] rec_position,
  output logic [dtw_dwidth-1:0] rec_minval,
  output logic                  rec_hit,
  output logic                  best_valid,
  output logic [axi_dwidth-1:0] best_qid,
  output logic [axi_dwidth-1:0] best_position,
  output logic [dtw_dwidth-1:0] best_minval,
  output logic [CNT_WIDTH-1:0]  rec_count,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic                  frame_err,
  output logic                  busy
);

  localparam logic [1:0] S_REQ = 2'd0;
  localparam logic [1:0] S_CAP = 2'd1;
  localparam logic [1:0] S_OUT = 2'd2;

  logic [1:0]            state, state_nxt;
  logic [1:0]            widx, widx_nxt;
  logic                  cap_en;
  logic                  last_word;
  logic                  accept;
  logic [axi_dwidth-1:0] slot_qid;
  logic [axi_dwidth-1:0] slot_pos;
  logic [dtw_dwidth-1:0] word_minval;
  logic                  word_upper_nz;

  assign accept        = rec_valid & rec_ready;
  assign last_word     = (widx == 2'd2);
  assign word_minval   = fifo_data[dtw_dwidth-1:0];
  assign word_upper_nz = |fifo_data[axi_dwidth-1:dtw_dwidth];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_REQ;
      widx  <= 2'd0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      widx  <= widx_nxt;
      busy  <= (widx_nxt != 2'd0) | (state_nxt != S_REQ);
    end
  end

  // Next-state, read request and capture strobe
  always_comb begin
    state_nxt = state;
    widx_nxt  = widx;
    fifo_rden = 1'b0;
    cap_en    = 1'b0;
    case (state)
      S_REQ: begin
        if (enable && !fifo_empty) begin
          fifo_rden = 1'b1;
          state_nxt = S_CAP;
        end
      end
      S_CAP: begin
        cap_en = 1'b1;
        if (last_word) begin
          widx_nxt  = 2'd0;
          state_nxt = S_OUT;
        end else begin
          widx_nxt  = widx + 2'd1;
          state_nxt = S_REQ;
        end
      end
      S_OUT: begin
        if (rec_ready) state_nxt = S_REQ;
      end
      default: state_nxt = S_REQ;
    endcase
  end

  // Word slots and the presented record
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_qid     <= '0;
      slot_pos     <= '0;
      rec_valid    <= 1'b0;
      rec_qid      <= '0;
      rec_position <= '0;
      rec_minval   <= '0;
      rec_hit      <= 1'b0;
    end else if (cap_en) begin
      case (widx)
        2'd0: slot_qid <= fifo_data;
        2'd1: slot_pos <= fifo_data;
        default: begin
          rec_qid      <= slot_qid;
          rec_position <= slot_pos;
          rec_minval   <= word_minval;
          rec_hit      <= (word_minval < threshold);
          rec_valid    <= 1'b1;
        end
      endcase
    end else if (accept) begin
      rec_valid <= 1'b0;
    end
  end

  // Statistics; clear takes priority over a same-cycle accept or frame error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rec_count     <= '0;
      hit_count     <= '0;
      best_valid    <= 1'b0;
      best_qid      <= '0;
      best_position <= '0;
      best_minval   <= '0;
      frame_err     <= 1'b0;
    end else if (clear) begin
      rec_count     <= '0;
      hit_count     <= '0;
      best_valid    <= 1'b0;
      best_qid      <= '0;
      best_position <= '0;
      best_minval   <= '0;
      frame_err     <= 1'b0;
    end else begin
      if (cap_en && last_word && word_upper_nz) frame_err <= 1'b1;
      if (accept) begin
        if (rec_count != '1) rec_count <= rec_count + CNT_WIDTH'(1);
        if (rec_hit) begin
          if (hit_count != '1) hit_count <= hit_count + CNT_WIDTH'(1);
          // strict compare: equal-cost later hits keep the earlier record
          if (!best_valid || (rec_minval < best_minval)) begin
            best_valid    <= 1'b1;
            best_qid      <= rec_qid;
            best_position <= rec_position;
            best_minval   <= rec_minval;
          end
        end
      end
    end
  end

endmodule
